// File: rtl/alu_seq.sv
// Multi-cycle parametrised ALU with start/done handshake and registered condition flag.
// Single-cycle ops complete on the accept edge; shifts and multiply iterate one step per edge.

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_DIST  = 3'd1,
        OP_MATCH = 3'd2,
        OP_LT    = 3'd3,
        OP_LSL   = 3'd4,
        OP_LSR   = 3'd5,
        OP_MUL   = 3'd6,
        OP_EQZ   = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int HALF = WIDTH / 2;

    state_t             r_state;
    op_t                r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [SHW:0]       r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_flag;
    logic               r_busy;
    logic               r_done;

    op_t                w_op;
    logic [WIDTH:0]     w_add_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_abs;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_sh_val;
    logic               w_sh_out;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic               w_last_step;

    assign w_op      = op_t'(op);
    assign w_add_sum = {1'b0, in1} + {1'b0, in2};
    // Sign-extended difference cannot overflow in WIDTH+1 bits, so its MSB is the signed compare.
    assign w_diff    = {in1[WIDTH-1], in1} - {in2[WIDTH-1], in2};
    assign w_abs     = w_diff[WIDTH] ? (~w_diff + (WIDTH+1)'(1)) : w_diff;
    assign w_shamt   = in2[SHW-1:0];

    assign w_sh_val  = (r_op == OP_LSL) ? {r_a[WIDTH-2:0], 1'b0} : {1'b0, r_a[WIDTH-1:1]};
    assign w_sh_out  = (r_op == OP_LSL) ? r_a[WIDTH-1] : r_a[0];

    // Add the multiplicand into the upper half, then shift the whole accumulator right.
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};
    assign w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_last_step = (r_cnt == (SHW+1)'(1));

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flag   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (w_op)
                            OP_ADD: begin
                                r_result <= w_add_sum[WIDTH-1:0];
                                r_flag   <= w_add_sum[WIDTH];
                                r_done   <= 1'b1;
                            end
                            OP_DIST: begin
                                r_result <= w_abs[WIDTH-1:0];
                                r_flag   <= w_diff[WIDTH];
                                r_done   <= 1'b1;
                            end
                            OP_MATCH: begin
                                r_flag <= (in1[HALF-1:0] == in2[HALF-1:0]);
                                r_done <= 1'b1;
                            end
                            OP_LT: begin
                                r_flag <= (in1 < in2);
                                r_done <= 1'b1;
                            end
                            OP_EQZ: begin
                                r_flag <= (in2 == '0);
                                r_done <= 1'b1;
                            end
                            OP_LSL, OP_LSR: begin
                                if (w_shamt == '0) begin
                                    r_result <= in1;
                                    r_flag   <= 1'b0;
                                    r_done   <= 1'b1;
                                end else begin
                                    r_op    <= w_op;
                                    r_a     <= in1;
                                    r_cnt   <= {1'b0, w_shamt};
                                    r_busy  <= 1'b1;
                                    r_state <= ST_RUN;
                                end
                            end
                            OP_MUL: begin
                                r_op    <= OP_MUL;
                                r_a     <= in1;
                                r_b     <= in2;
                                r_acc   <= '0;
                                r_cnt   <= (SHW+1)'(WIDTH);
                                r_busy  <= 1'b1;
                                r_state <= ST_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - (SHW+1)'(1);
                    if (r_op == OP_MUL) begin
                        r_acc <= w_mul_next;
                        r_b   <= {1'b0, r_b[WIDTH-1:1]};
                        if (w_last_step) begin
                            r_result <= w_mul_next[WIDTH-1:0];
                            r_flag   <= |w_mul_next[2*WIDTH-1:WIDTH];
                        end
                    end else begin
                        r_a <= w_sh_val;
                        if (w_last_step) begin
                            r_result <= w_sh_val;
                            r_flag   <= w_sh_out;
                        end
                    end
                    if (w_last_step) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign flag   = r_flag;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU; successor to the 8-bit single-cycle datapath ALU. It keeps the registered condition flag and adds a start/done handshake, configurable datapath width, and iterative variable-distance shifts and multiply. It sits between the register file and writeback; the branch unit reads `flag`.

## Interface
- `WIDTH`, 8: datapath width in bits; even, at least 4.
- `SHW`, `$clog2(WIDTH)`: width of the shift-amount field taken from `in2`.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted on a rising edge only when `busy`=0.
- `op`  in  3  operation, sampled when the request is accepted.
- `in1`  in  WIDTH  operand A, sampled when the request is accepted.
- `in2`  in  WIDTH  operand B, sampled when the request is accepted.
- `result`  out  WIDTH  result register.
- `flag`  out  1  condition flag register.
- `busy`  out  1  high while a multi-cycle operation runs.
- `done`  out  1  one-cycle pulse when an operation completes.

## Operation
- Ops: 0 ADD, 1 DIST, 2 MATCH, 3 LT, 4 LSL, 5 LSR, 6 MUL, 7 EQZ.
- ADD: `result` = (in1+in2) mod 2^WIDTH; `flag` = carry out.
- DIST: `result` = |signed(in1) - signed(in2)|, computed in WIDTH+1 bits, low WIDTH bits kept; `flag` = signed(in1) < signed(in2).
- MATCH: `flag` = (in1[WIDTH/2-1:0] == in2[WIDTH/2-1:0]); `result` unchanged.
- LT: `flag` = in1 < in2, unsigned; `result` unchanged.
- EQZ: `flag` = (in2 == 0); `result` unchanged.
- LSL/LSR:
  - Shift `in1` by n = in2[SHW-1:0], one bit per cycle; zero fill.
  - `flag` = last bit shifted out, or 0 when n=0.
  - n=0 completes as a single-cycle op with `result`=in1.
- MUL: shift-add, one multiplier bit per cycle, WIDTH steps, 2*WIDTH-bit product.
  - `result` = low WIDTH bits of the product.
  - `flag` = 1 if the high WIDTH bits are nonzero.
- `result` and `flag` change only at completion; between operations they hold their values.
- Working registers are internal: operand copies, a 2*WIDTH-bit accumulator, and a step counter of SHW+1 bits.
- FSM states:
  - IDLE: `busy`=0. On an accepted `start`, a single-cycle op writes its outputs on that edge and stays in IDLE. A multi-cycle op loads the working registers and counter and goes to RUN.
  - RUN: `busy`=1; one step per edge. The edge that performs the final step writes `result`/`flag`, pulses `done`, and returns to IDLE.

## Timing
- Reset values: `result`=0, `flag`=0, `busy`=0, `done`=0, FSM=IDLE, counter=0.
- Reset asserted mid-RUN aborts the operation immediately; no `done` is produced.
- Single-cycle ops (ADD, DIST, MATCH, LT, EQZ, shift by 0): accepted at edge k; outputs and `done`=1 are visible after edge k.
- Shift by n≥1: accepted at edge k; `busy`=1 after k. Steps occur at edges k+1..k+n. After edge k+n: `done`=1, `busy`=0.
- MUL: as for shifts with n=WIDTH; `done` is visible after edge k+WIDTH.
- `done` is high for exactly one cycle per completed operation.
- `start` while `busy`=1 is ignored and not queued.
- Back-to-back operation: a `start` in the cycle where `done`=1 is accepted, since `busy` is already 0.
- Operand and `op` changes after the accept edge have no effect.
- `start` held high while IDLE issues one operation per edge for single-cycle ops.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert `reset` with no clock edge -> all outputs 0 immediately. Release, then ADD 200+100 -> `result`=0x2C, `flag`=1, `done` after 1 edge.
- DIST: in1=0x05, in2=0xFB -> `result`=10, `flag`=0. Then in1=0xFB, in2=0x05 -> `result`=10, `flag`=1.
- Flag-only ops:
  - MATCH in1=0x3A, in2=0xCA -> `flag`=1 and `result` keeps its prior value.
  - LT 0x7F,0x80 -> `flag`=1.
  - EQZ in2=0 -> `flag`=1.
- Shifts:
  - LSL in1=0x81 by 3 -> `busy` for 3 cycles, `result`=0x08, `flag`=0.
  - LSL 0x81 by 1 -> `result`=0x02, `flag`=1.
  - LSR 0x81 by 0 -> `result`=0x81, `flag`=0, `done` after 1 edge.
- MUL:
  - 16×17 -> `done` after 8 edges, `result`=0x10, `flag`=1.
  - 12×10 -> `result`=0x78, `flag`=0.
  - An ADD issued in the `done` cycle completes on the next edge.
- Handshake and reset:
  - Pulse `start` with ADD during MUL -> ignored; MUL result is unchanged.
  - Assert `reset` at MUL step 4 -> outputs 0 and no `done`. A following EQZ works normally.
